autoconfig_chain: RTL

AUTOCONFIG_CHAIN -- requirements
Module: autoconfig_chain

---
 rtl/autoconfig_pkg.sv | 66 ++++++
 rtl/autoconfig_chain_next_board.sv | 26 ++
 rtl/autoconfig_chain.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/autoconfig_pkg.sv
// Shared Zorro II autoconfig definitions: bus phases, size codes, register
// offsets (in ADDR[8:1] units) and the base-address compare mask helper.
package autoconfig_pkg;

    localparam int IDX_W = 3;

    localparam logic [15:0] ROM_DIAG_VEC = 16'h0008;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } ac_state_t;

    typedef enum logic [1:0] {
        Z2_IDLE = 2'd0,
        Z2_ADDR = 2'd1,
        Z2_DATA = 2'd2,
        Z2_END  = 2'd3
    } z2_state_t;

    typedef enum logic [2:0] {
        SZ_8M   = 3'b000,
        SZ_64K  = 3'b001,
        SZ_128K = 3'b010,
        SZ_256K = 3'b011,
        SZ_512K = 3'b100,
        SZ_1M   = 3'b101,
        SZ_2M   = 3'b110,
        SZ_4M   = 3'b111
    } z2_size_t;

    typedef enum logic [7:0] {
        REG_ER_TYPE   = 8'h00,
        REG_ER_SIZE   = 8'h01,
        REG_PROD_HI   = 8'h02,
        REG_PROD_LO   = 8'h03,
        REG_ER_FLAGS  = 8'h04,
        REG_MFG_FIRST = 8'h08,
        REG_MFG_LAST  = 8'h0B,
        REG_SER_FIRST = 8'h0C,
        REG_SER_LAST  = 8'h13,
        REG_ROM_FIRST = 8'h14,
        REG_ROM_LAST  = 8'h17,
        REG_RSVD0     = 8'h20,
        REG_RSVD1     = 8'h21,
        REG_BASE_HI   = 8'h24,
        REG_BASE_LO   = 8'h25,
        REG_SHUTUP    = 8'h26
    } ac_reg_t;

    // Bits of A23:A16 that take part in the base compare for a size code.
    function automatic logic [7:0] size_mask(input logic [2:0] code);
        case (code)
            SZ_64K:  return 8'hFF;
            SZ_128K: return 8'hFE;
            SZ_256K: return 8'hFC;
            SZ_512K: return 8'hF8;
            SZ_1M:   return 8'hF0;
            SZ_2M:   return 8'hE0;
            SZ_4M:   return 8'hC0;
            default: return 8'h80;
        endcase
    endfunction

endpackage

// File: rtl/autoconfig_chain_next_board.sv
// Priority encoder: lowest enabled board index, either from zero or above cur_idx.
module ac_next_board
    import autoconfig_pkg::*;
#(
    parameter int NUM_BOARDS = 3
) (
    input  logic [NUM_BOARDS-1:0] en,
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic                  from_start,
    output logic                  found,
    output logic [IDX_W-1:0]      next_idx
);

    // Scanning downwards lets the lowest qualifying index win.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (en[i] && (from_start || (i > int'(cur_idx)))) begin
                found    = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II autoconfig responder presenting NUM_BOARDS logical boards in turn.
// Build option: define AC_ROMVEC_EN to advertise a diag ROM vector on I/O boards.
module autoconfig_chain
    import autoconfig_pkg::*;
#(
    parameter int                    NUM_BOARDS   = 3,
    parameter logic [15:0]           MFG_ID       = 16'd2011,
    parameter logic [31:0]           SERIAL       = 32'd1,
    parameter logic [8*NUM_BOARDS-1:0] BOARD_PRODID = {8'd74, 8'd6, 8'h72},
    parameter logic [3*NUM_BOARDS-1:0] BOARD_SIZE   = {3'b001, 3'b010, 3'b000},
    parameter logic [NUM_BOARDS-1:0] BOARD_MEM    = 3'b001
) (
    input  logic                    CLK,
    input  logic                    RESET_n,
    input  logic [23:1]             ADDR,
    input  logic                    AS_n,
    input  logic                    RW,
    input  logic [3:0]              DIN,
    input  logic [1:0]              z2_state,
    input  logic                    CFGIN_n,
    input  logic [NUM_BOARDS-1:0]   BOARD_EN,
    output logic [3:0]              DOUT,
    output logic                    dtack,
    output logic                    autoconfig_cycle,
    output logic                    CFGOUT_n,
    output logic [NUM_BOARDS-1:0]   configured,
    output logic [8*NUM_BOARDS-1:0] base_addr,
    output logic [NUM_BOARDS-1:0]   board_hit
);

    ac_state_t        state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             cfgin, cfgout;
    logic [3:0]       pending;
    logic             first_found, succ_found;
    logic [IDX_W-1:0] first_idx, succ_idx;
    logic [IDX_W-1:0] cur_idx;
    logic             done_eff;
    logic [7:0]       reg_off;
    logic [2:0]       ser_sel;
    logic             access, wr_base_hi, wr_base_lo, wr_shutup, advance;
    logic             cur_mem, romvec;
    logic [2:0]       cur_size;
    logic [7:0]       cur_prod;
    logic [3:0]       rd_data;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^ADDR[15:9];

    ac_next_board #(.NUM_BOARDS(NUM_BOARDS)) u_first (
        .en         (BOARD_EN),
        .cur_idx    (idx),
        .from_start (1'b1),
        .found      (first_found),
        .next_idx   (first_idx)
    );

    ac_next_board #(.NUM_BOARDS(NUM_BOARDS)) u_succ (
        .en         (BOARD_EN),
        .cur_idx    (cur_idx),
        .from_start (1'b0),
        .found      (succ_found),
        .next_idx   (succ_idx)
    );

    // Straight out of reset the register holds IDLE; the start board is decoded
    // live so the chain already behaves as ACTIVE(lowest enabled) or DONE.
    assign cur_idx  = (state == ST_IDLE) ? first_idx : idx;
    assign done_eff = (state == ST_DONE) || ((state == ST_IDLE) && !first_found);

    always_ff @(posedge AS_n or negedge RESET_n) begin
        if (!RESET_n) begin
            cfgin  <= 1'b0;
            cfgout <= 1'b0;
        end else begin
            cfgin  <= !CFGIN_n;
            cfgout <= done_eff;
        end
    end

    assign CFGOUT_n         = !cfgout;
    assign autoconfig_cycle = (ADDR[23:16] == 8'hE8) && cfgin && !done_eff && !cfgout;

    assign reg_off    = ADDR[8:1];
    assign ser_sel    = 3'(reg_off - REG_SER_FIRST);
    assign access     = (z2_state == Z2_DATA) && autoconfig_cycle && !dtack;
    assign wr_base_hi = access && !RW && (reg_off == REG_BASE_HI);
    assign wr_base_lo = access && !RW && (reg_off == REG_BASE_LO);
    assign wr_shutup  = access && !RW && (reg_off == REG_SHUTUP);
    assign advance    = wr_base_hi || wr_shutup;

    always_comb begin
        cur_mem  = 1'b0;
        cur_size = '0;
        cur_prod = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (cur_idx == IDX_W'(i)) begin
                cur_mem  = BOARD_MEM[i];
                cur_size = BOARD_SIZE[3*i +: 3];
                cur_prod = BOARD_PRODID[8*i +: 8];
            end
        end
    end

`ifdef AC_ROMVEC_EN
    assign romvec = !cur_mem;
`else
    assign romvec = 1'b0;
`endif

    // Multi-nibble fields are read most-significant nibble first.
    always_comb begin
        rd_data = 4'hF;
        if (reg_off == REG_ER_TYPE) begin
            rd_data = {2'b11, cur_mem, romvec};
        end else if (reg_off == REG_ER_SIZE) begin
            rd_data = {1'b0, cur_size};
        end else if (reg_off == REG_PROD_HI) begin
            rd_data = ~cur_prod[7:4];
        end else if (reg_off == REG_PROD_LO) begin
            rd_data = ~cur_prod[3:0];
        end else if (reg_off == REG_ER_FLAGS) begin
            rd_data = ~{cur_mem, 3'b000};
        end else if ((reg_off >= REG_MFG_FIRST) && (reg_off <= REG_MFG_LAST)) begin
            rd_data = ~(4'(MFG_ID >> (4'd12 - {reg_off[1:0], 2'b00})));
        end else if ((reg_off >= REG_SER_FIRST) && (reg_off <= REG_SER_LAST)) begin
            rd_data = ~(4'(SERIAL >> (5'd28 - {ser_sel, 2'b00})));
        end else if ((reg_off >= REG_ROM_FIRST) && (reg_off <= REG_ROM_LAST)) begin
`ifdef AC_ROMVEC_EN
            rd_data = ~(4'(ROM_DIAG_VEC >> (4'd12 - {reg_off[1:0], 2'b00})));
`else
            rd_data = 4'hF;
`endif
        end else if ((reg_off == REG_RSVD0) || (reg_off == REG_RSVD1)) begin
            rd_data = 4'h0;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                state_nxt = first_found ? ST_ACTIVE : ST_DONE;
                idx_nxt   = first_idx;
            end
            default: ;
        endcase
        if (advance) begin
            state_nxt = succ_found ? ST_ACTIVE : ST_DONE;
            idx_nxt   = succ_found ? succ_idx : cur_idx;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            DOUT       <= 4'h0;
            dtack      <= 1'b0;
            configured <= '0;
            base_addr  <= '0;
            pending    <= 4'h0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            dtack <= access;
            if (access && RW) begin
                DOUT <= rd_data;
            end
            if (wr_base_lo) begin
                pending <= DIN;
            end
            for (int i = 0; i < NUM_BOARDS; i++) begin
                if (wr_base_hi && (cur_idx == IDX_W'(i))) begin
                    base_addr[8*i +: 8] <= {DIN, pending};
                    configured[i]       <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_hit
        localparam logic [7:0] MASK = size_mask(BOARD_SIZE[3*g +: 3]);
        assign board_hit[g] = configured[g] &&
                              (((ADDR[23:16] ^ base_addr[8*g +: 8]) & MASK) == 8'h00);
    end

endmodule
